// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S microphone receiver.
package i2s_pkg;

  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } i2s_channel_e;

  // Accumulator holds REDUCE_FACTOR sign-extended words without overflow.
  function automatic int acc_width(input int data_size, input int reduce_factor);
    return data_size + $clog2(reduce_factor);
  endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// Bit-clock divider: toggles i2s_clk every HALF system clocks and flags
// the cycle on which each rising or falling transition is registered.
module i2s_sck_gen #(
  parameter int HALF = 33
) (
  input  logic clk,
  input  logic rst_n,
  output logic i2s_clk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CNT_W-1:0] div_cnt;
  logic             wrap;

  assign wrap      = (div_cnt == CNT_W'(HALF - 1));
  assign rise_tick = wrap && !i2s_clk;
  assign fall_tick = wrap && i2s_clk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      i2s_clk <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      i2s_clk <= ~i2s_clk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S master receiver for one MEMS mic: captures one channel slot per frame,
// drops the settling frames, and averages REDUCE_FACTOR words per PCM sample.
module i2s_mic_rx
  import i2s_pkg::*;
#(
  parameter int DATA_SIZE      = 24,
  parameter int CLK_FREQ       = 100_000_000,
  parameter int I2S_CLK_FREQ   = 1_500_000,
  parameter int REDUCE_FACTOR  = 2,
  parameter int CHANNEL        = 0,
  parameter int STARTUP_FRAMES = 4096
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        i2s_clk,
  output logic                        i2s_ws,
  input  logic                        i2s_sd,
  output logic signed [DATA_SIZE-1:0] pcm_out,
  output logic                        pcm_ready
);

  localparam int HALF  = CLK_FREQ / (2 * I2S_CLK_FREQ);
  localparam int SHIFT = $clog2(REDUCE_FACTOR);
  localparam int ACC_W = acc_width(DATA_SIZE, REDUCE_FACTOR);
  localparam int RED_W = (SHIFT > 0) ? SHIFT : 1;
  localparam int SU_W  = $clog2(STARTUP_FRAMES + 2);
  localparam int BIT_W = $clog2(FRAME_BITS);

  localparam i2s_channel_e     SLOT_CH  = (CHANNEL == 0) ? LEFT : RIGHT;
  localparam logic [BIT_W-1:0] SLOT_OFS = (SLOT_CH == RIGHT) ? BIT_W'(SLOT_BITS) : '0;
  localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(DATA_SIZE);

  if (REDUCE_FACTOR < 1 || (REDUCE_FACTOR & (REDUCE_FACTOR - 1)) != 0) begin : g_bad_reduce
    $error("i2s_mic_rx: REDUCE_FACTOR must be a power of two >= 1");
  end
  if (DATA_SIZE < 1 || DATA_SIZE > SLOT_BITS - 1) begin : g_bad_size
    $error("i2s_mic_rx: DATA_SIZE must be within 1..31");
  end
  if (HALF < 2) begin : g_bad_half
    $error("i2s_mic_rx: CLK_FREQ / (2*I2S_CLK_FREQ) must be at least 2");
  end

  // Floor-rounded mean: arithmetic shift of the full-width sum.
  function automatic logic signed [DATA_SIZE-1:0] floor_avg(
    input logic signed [ACC_W-1:0] sum
  );
    return DATA_SIZE'(sum >>> SHIFT);
  endfunction

  logic                        rise_tick;
  logic                        fall_tick;
  logic [BIT_W-1:0]            bit_cnt;
  logic [BIT_W-1:0]            slot_idx;
  logic                        in_slot;
  logic [DATA_SIZE-1:0]        shift_reg;
  logic                        last_bit_p0;
  logic                        word_vld_p1;
  logic signed [DATA_SIZE-1:0] word_p1;
  logic [SU_W-1:0]             startup_cnt;
  logic                        startup_done;
  logic signed [ACC_W-1:0]     acc;
  logic signed [ACC_W-1:0]     acc_sum;
  logic [RED_W-1:0]            red_cnt;
  logic                        red_last;

  i2s_sck_gen #(
    .HALF(HALF)
  ) u_sck_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .i2s_clk  (i2s_clk),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  // Slot position relative to the captured channel; index 1 carries the MSB
  // because I2S data lags word select by one bit clock.
  assign slot_idx = bit_cnt - SLOT_OFS;
  assign in_slot  = (slot_idx != '0) && (slot_idx <= LAST_IDX);

  // Stage p0: frame position, word select and serial capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      i2s_ws      <= 1'b0;
      shift_reg   <= '0;
      last_bit_p0 <= 1'b0;
    end else begin
      last_bit_p0 <= rise_tick && (slot_idx == LAST_IDX);
      if (fall_tick) begin
        bit_cnt <= bit_cnt + 1'b1;
        // WS follows the MSB of the incremented bit counter.
        i2s_ws  <= bit_cnt[BIT_W-1] ^ (&bit_cnt[BIT_W-2:0]);
      end
      if (rise_tick && in_slot) begin
        shift_reg <= DATA_SIZE'({shift_reg, i2s_sd});
      end
    end
  end

  // Stage p1: completed word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_vld_p1 <= 1'b0;
    end else begin
      word_vld_p1 <= last_bit_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (last_bit_p0) begin
      word_p1 <= shift_reg;
    end
  end

  assign startup_done = (startup_cnt == SU_W'(STARTUP_FRAMES));
  assign acc_sum      = acc + ACC_W'(word_p1);
  assign red_last     = (red_cnt == RED_W'(REDUCE_FACTOR - 1));

  // Stage p2: settling discard and decimation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      startup_cnt <= '0;
      acc         <= '0;
      red_cnt     <= '0;
      pcm_out     <= '0;
      pcm_ready   <= 1'b0;
    end else begin
      pcm_ready <= 1'b0;
      if (word_vld_p1) begin
        if (!startup_done) begin
          startup_cnt <= startup_cnt + 1'b1;
        end else if (red_last) begin
          pcm_out   <= floor_avg(acc_sum);
          acc       <= '0;
          red_cnt   <= '0;
          pcm_ready <= 1'b1;
        end else begin
          acc     <= acc_sum;
          red_cnt <= red_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Directed bench for i2s_mic_rx: four configurations run side by side, each fed
// by a simple I2S microphone model driving data after every falling bit clock.
module tb_i2s_mic_rx;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst1_n;
  logic [N-1:0]       sck;
  logic [N-1:0]       ws;
  logic [N-1:0]       sd;
  logic [N-1:0]       rdy;
  logic [N-1:0][23:0] pcm;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t0     = 0;
  int last_edge1 = 0;
  int dbl    = 0;
  bit p1_done = 1'b0;
  logic mrst0, mrst1;

  // Mic model state
  logic [23:0] ltbl [N][8];
  logic [23:0] rword [N];
  logic [23:0] cur [N];
  int          idx [N];
  int          lptr [N];
  logic        pws [N];
  logic        psck [N];
  logic        prdy [N];

  logic [23:0] q0[$], q1[$], q2[$], q3[$];
  int          e3[$];

  // inst0: defaults (HALF=33, REDUCE_FACTOR=2) with no settling discard
  i2s_mic_rx #(.STARTUP_FRAMES(0)) u_def (
    .clk(clk), .rst_n(rst_n), .i2s_clk(sck[0]), .i2s_ws(ws[0]), .i2s_sd(sd[0]),
    .pcm_out(pcm[0]), .pcm_ready(rdy[0]));

  // inst1: HALF=4, pass-through, left channel, own reset
  i2s_mic_rx #(.I2S_CLK_FREQ(12_500_000), .REDUCE_FACTOR(1), .STARTUP_FRAMES(0)) u_rf1 (
    .clk(clk), .rst_n(rst1_n), .i2s_clk(sck[1]), .i2s_ws(ws[1]), .i2s_sd(sd[1]),
    .pcm_out(pcm[1]), .pcm_ready(rdy[1]));

  // inst2: HALF=4, pass-through, right channel
  i2s_mic_rx #(.I2S_CLK_FREQ(12_500_000), .REDUCE_FACTOR(1), .CHANNEL(1),
               .STARTUP_FRAMES(0)) u_ch1 (
    .clk(clk), .rst_n(rst_n), .i2s_clk(sck[2]), .i2s_ws(ws[2]), .i2s_sd(sd[2]),
    .pcm_out(pcm[2]), .pcm_ready(rdy[2]));

  // inst3: HALF=4, average of two, three settling frames
  i2s_mic_rx #(.I2S_CLK_FREQ(12_500_000), .REDUCE_FACTOR(2), .STARTUP_FRAMES(3)) u_su (
    .clk(clk), .rst_n(rst_n), .i2s_clk(sck[3]), .i2s_ws(ws[3]), .i2s_sd(sd[3]),
    .pcm_out(pcm[3]), .pcm_ready(rdy[3]));

  task automatic check_eq(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Waits for a DUT pin (kind 0 = i2s_clk, 1 = i2s_ws) to reach lvl; returns
  // the clk edge number since t0, or -1 if the bound expires.
  task automatic wait_sig(input int kind, input int inst, input logic lvl,
                          input int limit, output int edge_no);
    edge_no = -1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (((kind == 0) ? sck[inst] : ws[inst]) == lvl) begin
        edge_no = cyc - t0;
        break;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    mrst0 <= !rst_n;
    mrst1 <= !rst1_n;
  end

  initial begin
    for (int k = 0; k < 8; k++) begin
      ltbl[0][k] = 24'h000000;
      ltbl[1][k] = 24'h123456;
      ltbl[2][k] = 24'hAAAAAA;
      ltbl[3][k] = 24'h000000;
    end
    ltbl[0][0] = 24'h000010; ltbl[0][1] = 24'h000020;
    ltbl[0][2] = 24'hFFFFFD; ltbl[0][3] = 24'hFFFFFC;
    ltbl[3][0] = 24'd1; ltbl[3][1] = 24'd2; ltbl[3][2] = 24'd3;
    ltbl[3][3] = 24'd4; ltbl[3][4] = 24'd6;
    rword[0] = 24'h7FFFFF;
    rword[1] = 24'hFFFFFF;
    rword[2] = 24'h0F0F0F;
    rword[3] = 24'h555555;
    for (int i = 0; i < N; i++) prdy[i] = 1'b0;
  end

  // Microphone model: after WS toggles, one idle bit, then the word MSB first.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if ((i == 1) ? mrst1 : mrst0) begin
        idx[i] = 0; lptr[i] = 0; pws[i] = 1'b0; psck[i] = 1'b0;
        cur[i] = '0; sd[i] = 1'b0;
      end else begin
        if (i == 1 && !psck[i] && sck[i] && !ws[i] && idx[i] == 24) last_edge1 = cyc;
        if (psck[i] && !sck[i]) begin
          idx[i] = (ws[i] != pws[i]) ? 0 : idx[i] + 1;
          pws[i] = ws[i];
          if (idx[i] == 1) begin
            cur[i] = ws[i] ? rword[i] : ltbl[i][lptr[i]];
            if (!ws[i] && lptr[i] < 7) lptr[i]++;
          end
          sd[i] = (idx[i] >= 1 && idx[i] <= 24) ? cur[i][24 - idx[i]] : 1'b0;
        end
        psck[i] = sck[i];
      end
    end
  end

  // Strobe recorder
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rdy[i] && prdy[i]) dbl++;
      prdy[i] = rdy[i];
    end
    if (rdy[0]) q0.push_back(pcm[0]);
    if (rdy[1]) begin
      q1.push_back(pcm[1]);
      check_eq("rf1_latency", cyc - last_edge1, 2);
    end
    if (rdy[2]) q2.push_back(pcm[2]);
    if (rdy[3]) begin
      q3.push_back(pcm[3]);
      e3.push_back(cyc - t0);
    end
  end

  // Pass-through instance with a mid-word reset
  initial begin
    int tr;
    int e;
    rst1_n = 1'b0;
    repeat (3) @(negedge clk);
    rst1_n = 1'b1;
    tr = cyc;
    while (cyc - tr < 1624) @(negedge clk);
    check_eq("rf1_count", q1.size(), 3);
    check_eq("rf1_word0", (q1.size() > 0) ? int'(q1[0]) : -1, 32'h123456);
    check_eq("rf1_word2", (q1.size() > 2) ? int'(q1[2]) : -1, 32'h123456);
    rst1_n = 1'b0;
    @(negedge clk);
    check_eq("rf1_rst_sck", int'(sck[1]), 0);
    check_eq("rf1_rst_ws", int'(ws[1]), 0);
    check_eq("rf1_rst_pcm", int'(pcm[1]), 0);
    check_eq("rf1_rst_rdy", int'(rdy[1]), 0);
    rst1_n = 1'b1;
    tr = cyc;
    while (cyc - tr < 150) @(negedge clk);
    check_eq("rf1_no_partial", q1.size(), 3);
    e = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rdy[1]) begin
        e = cyc - tr;
        break;
      end
    end
    check_eq("rf1_restart_edge", e, 198);
    check_eq("rf1_restart_pcm", int'(pcm[1]), 32'h123456);
    p1_done = 1'b1;
  end

  initial begin
    int r1, r2, fl, w1, wf, w2;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_sck", int'(sck[0]), 0);
    check_eq("rst_ws", int'(ws[0]), 0);
    check_eq("rst_pcm", int'(pcm[0]), 0);
    check_eq("rst_rdy", int'(rdy), 0);
    rst_n = 1'b1;
    t0 = cyc;

    wait_sig(0, 0, 1'b1, 200, r1);
    check_eq("first_rise_edge", r1, 33);
    wait_sig(0, 0, 1'b0, 200, fl);
    wait_sig(0, 0, 1'b1, 200, r2);
    check_eq("sck_period", r2 - r1, 66);
    wait_sig(1, 0, 1'b1, 6000, w1);
    check_eq("ws_first_rise", w1, 2112);
    wait_sig(1, 0, 1'b0, 6000, wf);
    wait_sig(1, 0, 1'b1, 6000, w2);
    check_eq("ws_period", w2 - w1, 4224);
    check_eq("ws_high_time", wf - w1, 2112);

    while (cyc - t0 < 16000) @(negedge clk);
    check_eq("avg_count", q0.size(), 2);
    check_eq("avg_pos", (q0.size() > 0) ? int'(q0[0]) : -1, 32'h000018);
    check_eq("avg_neg_floor", (q0.size() > 1) ? int'(q0[1]) : -1, 32'hFFFFFC);
    check_eq("right_count", q2.size(), 31);
    check_eq("right_first", (q2.size() > 0) ? int'(q2[0]) : -1, 32'h0F0F0F);
    check_eq("right_last", (q2.size() > 0) ? int'(q2[q2.size() - 1]) : -1, 32'h0F0F0F);
    check_eq("startup_first", (q3.size() > 0) ? int'(q3[0]) : -1, 5);
    check_eq("startup_edge", (e3.size() > 0) ? e3[0] : -1, 2246);
    check_eq("startup_second", (q3.size() > 1) ? int'(q3[1]) : -1, 0);

    for (int k = 0; k < 5000 && !p1_done; k++) @(negedge clk);
    check_eq("reset_seq_done", int'(p1_done), 1);
    check_eq("double_strobe", dbl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_mic_rx.md
# i2s_mic_rx

I2S master receiver for a single MEMS microphone: generates the bit clock and word select, deserialises one 24-bit channel slot per frame, and averages `REDUCE_FACTOR` consecutive words into one PCM sample. It sits directly upstream of the sample-to-FIFO byte packer in the capture top level. It presents `pcm_out` with a one-cycle `pcm_ready` strobe per decimated sample.

## Interface
- `DATA_SIZE`, 24: bits captured per slot, MSB first; 1..31.
- `CLK_FREQ`, 100_000_000: system clock in Hz.
- `I2S_CLK_FREQ`, 1_500_000: target bit clock. `HALF = CLK_FREQ/(2*I2S_CLK_FREQ)` (integer floor, 33 by default, must be ≥2).
- `REDUCE_FACTOR`, 2: words averaged per output; power of two, ≥1 (elaboration assertion).
- `CHANNEL`, 0: slot captured. 0 = left (WS low), 1 = right (WS high).
- `STARTUP_FRAMES`, 4096: frames discarded after reset (mic settling, 2^18 SCK).
- `clk` in 1: system clock. One clock domain; reset is synchronous and active-low.
- `rst_n` in 1: synchronous, active-low reset.
- `i2s_clk` out 1: bit clock (SCK). Registered.
- `i2s_ws` out 1: word select. Registered.
- `i2s_sd` in 1: serial data from the mic. Already metastability-safe by slow SCK; sampled directly.
- `pcm_out` out DATA_SIZE: signed decimated sample. Held until the next update.
- `pcm_ready` out 1: one-clk strobe when `pcm_out` updates.

## Operation
- Reset values: `i2s_clk`=0, `i2s_ws`=0, `pcm_out`=0, `pcm_ready`=0. All counters, shift register, and accumulator are also cleared.
- Divider: `div_cnt` counts 0..HALF-1. At HALF-1 it wraps and toggles `i2s_clk`.
  - A toggle 0→1 is a rise tick.
  - A toggle 1→0 is a fall tick.
- Frame: 64 SCK, 32 slots per channel. `bit_cnt` (6 bits) increments on each fall tick and wraps 63→0. `i2s_ws` is registered as `bit_cnt[5]` at the fall tick.
- Capture: on a rise tick with slot index `bit_cnt - 32*CHANNEL` in 1..DATA_SIZE, shift `i2s_sd` into the shift register LSB. Slot index 1 is the MSB (standard I2S one-bit delay).
- Word complete: at the rise tick with slot index == DATA_SIZE. Slot bits beyond DATA_SIZE and the other channel are ignored.
- Startup: a frame counter discards the first `STARTUP_FRAMES` completed words. The counter saturates and never re-arms except by reset.
- Decimation:
  - The accumulator is `DATA_SIZE + log2(REDUCE_FACTOR)` bits. Each word is sign-extended and added.
  - On the `REDUCE_FACTOR`-th word: `pcm_out <= (acc + word) >>> log2(REDUCE_FACTOR)`, truncated to DATA_SIZE. This is floor rounding. Then `acc <= 0` and `pcm_ready` pulses.
  - REDUCE_FACTOR=1 is a pure pass-through.
- Reset mid-operation discards any partial word and partial accumulation. Startup discard restarts from zero.
- No backpressure. The consumer must accept every strobe.

## Timing
- The first `i2s_clk` rise occurs on the HALF-th clk edge after `rst_n` deasserts. SCK period is 2·HALF clk; frame period is 128·HALF clk.
- `i2s_ws` changes on the same clk edge as a falling `i2s_clk`.
- `i2s_sd` is sampled on the same clk edge that drives `i2s_clk` high.
- The word-complete flag is registered one clk after the sampling edge of the last bit. `pcm_out`/`pcm_ready` update on the following edge, so latency is 2 clk from the last-bit sample to the strobe.
- `pcm_ready` is high for exactly 1 clk per `REDUCE_FACTOR` frames; it never rises twice within one frame.
- A strobe never coincides with reset: `rst_n` low forces `pcm_ready` 0 on that edge.

## Structure
- `i2s_pkg`:
  - `FRAME_BITS`=64 and `SLOT_BITS`=32.
  - `i2s_channel_e` (LEFT=0, RIGHT=1).
  - A `clog2`-based accumulator-width function.
- Sub-module `i2s_sck_gen`: divider, `i2s_clk` register, and `rise_tick`/`fall_tick` outputs.
- Capture, startup counter, and decimator stay in the top of this block.

## Test plan
- Reset (defaults, STARTUP_FRAMES=0) → all outputs 0 during reset; first `i2s_clk` rise on clk edge 33 after release; SCK period 66 clk; WS period 4224 clk with 50% duty.
- REDUCE_FACTOR=1, left slot 0x123456, right slot 0xFFFFFF → `pcm_out`=0x123456 each frame. Strobe exactly 2 clk after the bit-24 sample; one strobe per frame.
- REDUCE_FACTOR=2, words 0x000010, 0x000020 → 0x000018. Words 0xFFFFFD, 0xFFFFFC → 0xFFFFFC (floor of −3.5).
- CHANNEL=1, left 0xAAAAAA, right 0x0F0F0F, REDUCE_FACTOR=1 → `pcm_out`=0x0F0F0F.
- STARTUP_FRAMES=3, REDUCE_FACTOR=2, words 1,2,3,4,6 → first three words dropped; single strobe with `pcm_out`=5.
- `rst_n` low for 1 clk at bit 10 of the left slot → no strobe from the partial word; outputs return to reset values; the next full word is captured correctly.
